// File: rtl/apple2_disk_pkg.sv
// Shared types and helpers for the multi-drive Disk II track cache.
package apple2_disk_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, LOAD} state_t;

    localparam int SECTOR_BYTES = 512;

    // First SD sector of a track: tracks are stored back to back in the image.
    function automatic logic [31:0] trk2lba(input logic [31:0] trk, input logic [31:0] secs);
        return trk * secs;
    endfunction

endpackage

// File: rtl/sd_sector_seq.sv
// Sector-by-sector hps_io handshake shared by track flush and track load:
// edge-detects ack, advances the LBA on each rise and the sector index on each fall.
module sd_sector_seq
    import apple2_disk_pkg::*;
#(
    parameter int SECS_PER_TRACK = 13,
    parameter int LBA_W          = 32,
    parameter int SEC_W          = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_wr,
    input  logic [LBA_W-1:0] start_lba,
    input  logic             ack,
    input  logic             abort,
    output logic             rd,
    output logic             wr,
    output logic [LBA_W-1:0] lba,
    output logic [SEC_W-1:0] sec,
    output logic             fall,
    output logic             done
);

    logic old_ack;
    logic active;
    logic stop;
    logic req;
    logic ack_rise;
    logic ack_fall;

    assign req      = rd | wr;
    assign ack_rise = ack & ~old_ack & active;
    assign ack_fall = ~ack & old_ack & active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old_ack <= 1'b0;
            active  <= 1'b0;
            stop    <= 1'b0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            lba     <= '0;
            sec     <= '0;
            fall    <= 1'b0;
            done    <= 1'b0;
        end else begin
            old_ack <= ack;
            fall    <= 1'b0;
            done    <= 1'b0;
            if (start) begin
                active <= 1'b1;
                stop   <= 1'b0;
                rd     <= ~start_wr;
                wr     <= start_wr;
                lba    <= start_lba;
                sec    <= '0;
            end else begin
                // A remount lets the sector in flight finish, then ends the transfer.
                if (abort)
                    stop <= 1'b1;
                if (ack_rise && req) begin
                    lba <= lba + LBA_W'(1);
                    if (sec == SEC_W'(SECS_PER_TRACK - 1) || stop || abort) begin
                        rd <= 1'b0;
                        wr <= 1'b0;
                    end
                end
                if (ack_fall) begin
                    fall <= 1'b1;
                    if (req) begin
                        sec <= sec + SEC_W'(1);
                    end else begin
                        done   <= 1'b1;
                        active <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/disk_track_cache_ctrl.sv
// Multi-drive Disk II track cache: loads whole tracks from the SD image into
// track RAM and writes dirty tracks back before they are replaced.
module disk_track_cache_ctrl
    import apple2_disk_pkg::*;
#(
    parameter int NUM_DRIVES     = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_W        = 6,
    parameter int LBA_W          = 32,
    parameter bit WAIT_FULL      = 1'b0,
    localparam int DRV_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1,
    localparam int SEC_W = (SECS_PER_TRACK > 1) ? $clog2(SECS_PER_TRACK) : 1
)(
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [DRV_W-1:0]              drive_sel,
    input  logic [TRACK_W*NUM_DRIVES-1:0] track,
    input  logic [NUM_DRIVES-1:0]         track_dirty,
    input  logic [NUM_DRIVES-1:0]         img_mounted,
    input  logic [NUM_DRIVES-1:0]         img_present,
    input  logic [NUM_DRIVES-1:0]         img_readonly,
    output logic [LBA_W-1:0]              sd_lba,
    output logic [NUM_DRIVES-1:0]         sd_rd,
    output logic [NUM_DRIVES-1:0]         sd_wr,
    input  logic [NUM_DRIVES-1:0]         sd_ack,
    output logic [DRV_W-1:0]              xfer_drive,
    output logic [SEC_W-1:0]              track_sec,
    output logic                          cpu_wait,
    output logic                          busy
);

    state_t               state;
    logic [TRACK_W-1:0]   cur_track [NUM_DRIVES];
    logic [TRACK_W-1:0]   req_trk   [NUM_DRIVES];
    logic [TRACK_W-1:0]   new_trk;
    logic [NUM_DRIVES-1:0] dirty;
    logic [NUM_DRIVES-1:0] pend;
    logic [NUM_DRIVES-1:0] avail;
    logic [DRV_W-1:0]     pick;
    logic [DRV_W-1:0]     load_drv;
    logic [TRACK_W-1:0]   load_trk;
    logic                 load;
    logic                 start;
    logic                 start_wr;
    logic [LBA_W-1:0]     start_lba;
    logic                 seq_rd;
    logic                 seq_wr;
    logic                 seq_fall;
    logic                 seq_done;

    always_comb begin
        for (int d = 0; d < NUM_DRIVES; d++)
            req_trk[d] = track[d*TRACK_W +: TRACK_W];
    end

    // Arbitration: the drive the CPU is looking at first, else the lowest index.
    always_comb begin
        avail = pend & img_present;
        pick  = '0;
        for (int d = NUM_DRIVES - 1; d >= 0; d--)
            if (avail[d])
                pick = DRV_W'(d);
        if (avail[drive_sel])
            pick = drive_sel;
    end

    always_comb begin
        start     = 1'b0;
        start_wr  = 1'b0;
        start_lba = '0;
        load      = 1'b0;
        load_trk  = new_trk;
        load_drv  = xfer_drive;
        if (state == IDLE && avail != '0) begin
            start    = 1'b1;
            load_drv = pick;
            if (dirty[pick] && !img_readonly[pick]) begin
                start_wr  = 1'b1;
                start_lba = LBA_W'(trk2lba(32'(cur_track[pick]), 32'(SECS_PER_TRACK)));
            end else begin
                load     = 1'b1;
                load_trk = req_trk[pick];
            end
        end else if (state == FLUSH && seq_done) begin
            start = 1'b1;
            load  = 1'b1;
        end
        if (load)
            start_lba = LBA_W'(trk2lba(32'(load_trk), 32'(SECS_PER_TRACK)));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            xfer_drive <= '0;
            new_trk    <= '0;
            cpu_wait   <= 1'b0;
            dirty      <= '0;
            pend       <= '0;
            for (int d = 0; d < NUM_DRIVES; d++)
                cur_track[d] <= '1;
        end else begin
            for (int d = 0; d < NUM_DRIVES; d++) begin
                if (req_trk[d] != cur_track[d] || img_mounted[d])
                    pend[d] <= 1'b1;
                if (img_mounted[d])
                    dirty[d] <= 1'b0;
                else if (track_dirty[d])
                    dirty[d] <= 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    xfer_drive <= pick;
                    new_trk    <= req_trk[pick];
                    state      <= load ? LOAD : FLUSH;
                end
                FLUSH: if (seq_done) begin
                    dirty[xfer_drive] <= 1'b0;
                    state             <= LOAD;
                end
                LOAD: begin
                    if (seq_fall && !WAIT_FULL)
                        cpu_wait <= 1'b0;
                    if (seq_done) begin
                        cpu_wait <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                cur_track[load_drv] <= load_trk;
                pend[load_drv]      <= 1'b0;
                cpu_wait            <= (load_drv == drive_sel);
            end
        end
    end

    sd_sector_seq #(
        .SECS_PER_TRACK (SECS_PER_TRACK),
        .LBA_W          (LBA_W),
        .SEC_W          (SEC_W)
    ) u_seq (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .start     (start),
        .start_wr  (start_wr),
        .start_lba (start_lba),
        .ack       (sd_ack[xfer_drive]),
        .abort     (img_mounted[xfer_drive] && state != IDLE),
        .rd        (seq_rd),
        .wr        (seq_wr),
        .lba       (sd_lba),
        .sec       (track_sec),
        .fall      (seq_fall),
        .done      (seq_done)
    );

    assign sd_rd = seq_rd ? (NUM_DRIVES'(1) << xfer_drive) : '0;
    assign sd_wr = seq_wr ? (NUM_DRIVES'(1) << xfer_drive) : '0;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_disk_track_cache_ctrl.sv
// Bench for disk_track_cache_ctrl: an hps_io responder acks every sector and
// compares each one against a queue of expected (drive, direction, lba, sector).
module tb_disk_track_cache_ctrl;

    localparam int SECS = 13;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [0:0]  drive_sel;
    logic [11:0] track;
    logic [1:0]  track_dirty, img_mounted, img_present, img_readonly, sd_ack;

    logic [31:0] sd_lba0, sd_lba1;
    logic [1:0]  sd_rd0, sd_rd1, sd_wr0, sd_wr1;
    logic [0:0]  xfer_drive0, xfer_drive1;
    logic [3:0]  track_sec0, track_sec1;
    logic        cpu_wait0, cpu_wait1, busy0, busy1;

    always #5 clk_sys = ~clk_sys;

    disk_track_cache_ctrl dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .drive_sel(drive_sel), .track(track),
        .track_dirty(track_dirty), .img_mounted(img_mounted), .img_present(img_present),
        .img_readonly(img_readonly), .sd_lba(sd_lba0), .sd_rd(sd_rd0), .sd_wr(sd_wr0),
        .sd_ack(sd_ack), .xfer_drive(xfer_drive0), .track_sec(track_sec0),
        .cpu_wait(cpu_wait0), .busy(busy0)
    );

    disk_track_cache_ctrl #(.WAIT_FULL(1'b1)) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .drive_sel(drive_sel), .track(track),
        .track_dirty(track_dirty), .img_mounted(img_mounted), .img_present(img_present),
        .img_readonly(img_readonly), .sd_lba(sd_lba1), .sd_rd(sd_rd1), .sd_wr(sd_wr1),
        .sd_ack(sd_ack), .xfer_drive(xfer_drive1), .track_sec(track_sec1),
        .cpu_wait(cpu_wait1), .busy(busy1)
    );

    typedef struct { int drv; bit wr; int lba; int sec; } xfer_t;
    typedef struct {
        int drv; int trk; bit dirty; bit ro; bit mount; bit flush; int flush_base; int load_base;
    } row_t;

    xfer_t      exp_q[$];
    xfer_t      cur_e;
    row_t       rows[6];
    logic [1:0] ack_req;
    bit         ack_en = 1'b1;
    int         total  = 0;
    int         passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_track(input int drv, input bit wr, input int base);
        for (int k = 0; k < SECS; k++) exp_q.push_back('{drv, wr, base + k, k});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_lba0"}, sd_lba0, 0);
        chk({tag, "_ctl0"}, {sd_rd0, sd_wr0, xfer_drive0, track_sec0, cpu_wait0, busy0}, 0);
        chk({tag, "_lba1"}, sd_lba1, 0);
        chk({tag, "_ctl1"}, {sd_rd1, sd_wr1, xfer_drive1, track_sec1, cpu_wait1, busy1}, 0);
    endtask

    // hps_io responder: checks the request at each sector start, then pulses ack.
    initial begin : hps_model
        sd_ack = '0;
        forever begin
            @(posedge clk_sys); #1;
            if (ack_en && (sd_rd0 | sd_wr0) != '0) begin
                ack_req = sd_rd0 | sd_wr0;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_req: got lba %0d rd %b wr %b, expected no request",
                             sd_lba0, sd_rd0, sd_wr0);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk($sformatf("sec_lba[%0d]", cur_e.lba), sd_lba0, cur_e.lba);
                    chk($sformatf("sec_idx[%0d]", cur_e.lba), track_sec0, cur_e.sec);
                    chk($sformatf("sec_drive[%0d]", cur_e.lba), xfer_drive0, cur_e.drv);
                    chk($sformatf("sec_dir[%0d]", cur_e.lba), {sd_wr0, sd_rd0},
                        cur_e.wr ? (4'b0100 << cur_e.drv) : (4'b0001 << cur_e.drv));
                end
                repeat (2) @(posedge clk_sys);
                #1 sd_ack = ack_req;
                repeat (3) @(posedge clk_sys);
                #1 sd_ack = '0;
                @(posedge clk_sys);
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while ((exp_q.size() != 0 || busy0 || (sd_rd0 | sd_wr0) != '0) && n < 3000);
        chk({name, "_timeout"}, (n < 3000), 1);
        chk({name, "_leftover"}, exp_q.size(), 0);
    endtask

    task automatic apply_row(input int i);
        row_t r;
        r = rows[i];
        @(negedge clk_sys);
        drive_sel = r.drv[0];
        img_readonly[r.drv] = r.ro;
        if (r.dirty) begin
            track_dirty[r.drv] = 1'b1;
            @(negedge clk_sys);
            track_dirty = '0;
        end
        if (r.flush) push_track(r.drv, 1'b1, r.flush_base);
        push_track(r.drv, 1'b0, r.load_base);
        track[r.drv*6 +: 6] = 6'(r.trk);
        img_present[r.drv] = 1'b1;
        img_mounted[r.drv] = r.mount;
        @(negedge clk_sys);
        img_mounted = '0;
        wait_done($sformatf("row%0d", i));
    endtask

    initial begin
        int n, falls, rel0, rel1;
        logic prev;

        //          drv trk dirty ro   mount flush fbase lbase
        rows[0] = '{0,  5,  1'b0, 1'b0, 1'b1, 1'b0, 0,  65};
        rows[1] = '{0,  6,  1'b1, 1'b0, 1'b0, 1'b1, 65, 78};
        rows[2] = '{0,  7,  1'b0, 1'b0, 1'b0, 1'b0, 0,  91};
        rows[3] = '{0,  6,  1'b1, 1'b1, 1'b0, 1'b0, 0,  78};
        rows[4] = '{0,  6,  1'b0, 1'b0, 1'b1, 1'b0, 0,  78};
        rows[5] = '{1,  2,  1'b0, 1'b0, 1'b1, 1'b0, 0,  26};

        reset_n = 1'b0;
        drive_sel = '0;
        track = '0;
        track_dirty = '0;
        img_mounted = '0;
        img_present = '0;
        img_readonly = '0;
        repeat (3) @(negedge clk_sys);
        chk_reset("rst_hold");
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk_reset("rst_idle");

        for (int i = 0; i < 6; i++) apply_row(i);

        // cpu_wait release point: first ack fall (dut0) versus last ack fall (dut1).
        @(negedge clk_sys);
        drive_sel = 1'b0;
        push_track(0, 1'b0, 117);
        track[5:0] = 6'd9;
        n = 0;
        while (!busy0 && n < 50) begin @(negedge clk_sys); n++; end
        chk("wf_start", busy0, 1);
        chk("wf_wait_hi0", cpu_wait0, 1);
        chk("wf_wait_hi1", cpu_wait1, 1);
        rel0 = -1; rel1 = -1; falls = 0; n = 0;
        prev = sd_ack[0];
        while (busy0 && n < 3000) begin
            @(negedge clk_sys);
            n++;
            if (prev && !sd_ack[0]) falls++;
            prev = sd_ack[0];
            if (!cpu_wait0 && rel0 < 0) rel0 = falls;
            if (!cpu_wait1 && rel1 < 0) rel1 = falls;
        end
        chk("wf_release_fall_full0", rel0, 1);
        chk("wf_release_fall_full1", rel1, 13);
        chk("wf_falls", falls, 13);
        chk("wf_leftover", exp_q.size(), 0);

        // Both drives pending, drive_sel=1: drive 1 first, then drive 0.
        @(negedge clk_sys);
        drive_sel = 1'b1;
        push_track(1, 1'b0, 52);
        push_track(0, 1'b0, 39);
        track[5:0]  = 6'd3;
        track[11:6] = 6'd4;
        wait_done("both");

        // Reset in the middle of a load at sector 4, then remount and reload.
        @(negedge clk_sys);
        drive_sel = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back('{0, 1'b0, 104 + k, k});
        track[5:0] = 6'd8;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk_sys); n++; end
        chk("rst_reach_sec4", exp_q.size(), 0);
        chk("rst_mid_sec", track_sec0, 4);
        chk("rst_mid_wait1", cpu_wait1, 1);
        reset_n = 1'b0;
        ack_en = 1'b0;
        img_present = '0;
        #1 chk_reset("rst_mid");
        repeat (8) @(negedge clk_sys);
        chk_reset("rst_mid_hold");
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk_reset("rst_after");
        ack_en = 1'b1;
        push_track(0, 1'b0, 104);
        img_present[0] = 1'b1;
        img_mounted[0] = 1'b1;
        @(negedge clk_sys);
        img_mounted = '0;
        wait_done("reload");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
